// File: rtl/answer_pkg.sv
// Shared types and constants for the answer packetizer: FSM states, count width, DEPTH limits.
package answer_pkg;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    PREFETCH = 2'd1,
    READY    = 2'd2,
    SEND     = 2'd3
  } state_e;

  localparam int SIZE_W    = 12;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = (1 << SIZE_W) - 1;

  function automatic bit depth_ok(input int depth);
    return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
  endfunction

endpackage

// File: rtl/sync_ram_1r1w.sv
// Simple dual-port RAM, one write and one registered read port.
// Read data appears one cycle after the address; no backpressure, read-during-write returns old data.
module sync_ram_1r1w #(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11,
  parameter int WIDTH  = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
    rdata_q <= mem_q[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/answer_packetizer.sv
// Buffers one demodulated packet, then streams it out byte-by-byte; ready rises two edges after the last byte is sampled.
// Input has no backpressure (bytes arriving while busy or full are dropped, sticky overflow); output holds under i_tmanager_ready low.
module answer_packetizer
  import answer_pkg::*;
#(
  parameter int DEPTH = 2048
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_data,
  input  logic              i_data_valid,
  input  logic              i_data_last,
  input  logic              i_tmanager_ready,
  output logic              o_tanswer_ready,
  output logic [7:0]        o_tdata,
  output logic              o_tanswer_data_last,
  output logic [SIZE_W-1:0] o_packet_size_in_bytes,
  output logic              o_busy,
  output logic              o_full,
  output logic              o_overflow
);

  localparam int                ADDR_W    = $clog2(DEPTH);
  localparam logic [SIZE_W-1:0] DEPTH_CNT = SIZE_W'(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("answer_packetizer: DEPTH must be within 2..4095");
  end

  state_e              state_q, state_d;
  logic                in_vld_q, in_last_q;
  logic [7:0]          in_dat_q;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   rd_addr;
  logic [SIZE_W-1:0]   count_q, count_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic                ovf_q, ovf_d;
  logic                wr_en;
  logic [7:0]          rd_data;
  logic                full, xfer, at_last;

  // Input bytes are registered once so the RAM write precedes the address-0 prefetch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      in_vld_q  <= 1'b0;
      in_last_q <= 1'b0;
      in_dat_q  <= '0;
    end else begin
      in_vld_q  <= i_data_valid;
      in_last_q <= i_data_last;
      in_dat_q  <= i_data;
    end
  end

  assign full    = (count_q == DEPTH_CNT);
  assign xfer    = o_tanswer_ready && i_tmanager_ready;
  assign at_last = (SIZE_W'(rd_ptr_q) == (size_q - 1'b1));

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    size_d   = size_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    rd_addr  = rd_ptr_q;
    unique case (state_q)
      COLLECT: begin
        if (in_vld_q) begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
          end
          if (in_last_q) begin
            size_d  = full ? count_q : count_q + 1'b1;
            state_d = PREFETCH;
          end
        end
      end
      PREFETCH: begin
        rd_addr = '0;
        state_d = READY;
      end
      READY, SEND: begin
        if (in_vld_q) begin
          ovf_d = 1'b1;
        end
        // Advancing the read address on the transfer edge keeps the stream bubble-free.
        if (xfer) begin
          if (at_last) begin
            state_d  = COLLECT;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            size_d   = '0;
          end else begin
            state_d  = SEND;
            rd_ptr_d = rd_ptr_q + 1'b1;
            rd_addr  = rd_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
    if (state_q == PREFETCH && in_vld_q) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= COLLECT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      size_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      size_q   <= size_d;
      ovf_q    <= ovf_d;
    end
  end

  sync_ram_1r1w #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (8)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (wr_en),
    .i_waddr (wr_ptr_q),
    .i_wdata (in_dat_q),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  assign o_tanswer_ready        = (state_q == READY) || (state_q == SEND);
  assign o_tdata                = o_tanswer_ready ? rd_data : 8'h00;
  assign o_tanswer_data_last    = o_tanswer_ready && at_last;
  assign o_packet_size_in_bytes = size_q;
  assign o_busy                 = (state_q != COLLECT);
  assign o_full                 = (state_q == COLLECT) && full;
  assign o_overflow             = ovf_q;

endmodule
